// File: rtl/frame_buf_pingpong_if.sv
// Bus bundle for the ping-pong frame buffer: writer side, reader side and status.
interface frame_buf_pingpong_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) ();
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_frame_done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_frame_end;
  logic                  overrun_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_ready;
  logic                  wr_bank;
  logic                  frame_ready;
  logic                  overrun;
  logic [CNT_WIDTH-1:0]  swap_count;

  modport master (
    output wr_en, wr_addr, wr_data, wr_frame_done,
    output rd_en, rd_addr, rd_frame_end, overrun_clr,
    input  rd_data, rd_valid, wr_ready, wr_bank, frame_ready, overrun, swap_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_frame_done,
    input  rd_en, rd_addr, rd_frame_end, overrun_clr,
    output rd_data, rd_valid, wr_ready, wr_bank, frame_ready, overrun, swap_count
  );
endinterface

// File: rtl/frame_buf_pingpong.sv
// Double-buffered frame memory. The writer fills the back bank, the reader
// scans the front bank, and the banks swap only on frame boundaries so the
// reader never observes a partially written frame.
module frame_buf_pingpong #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) (
  input logic                 clk,
  input logic                 reset,
  frame_buf_pingpong_if.slave bus
);
  localparam int WORDS = 2 ** (ADDR_WIDTH + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    VALID   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  swap;
  logic                  front_sel_q;
  logic [CNT_WIDTH-1:0]  swap_count_q;
  logic                  overrun_q;
  logic                  overrun_set;
  logic                  wr_ready;
  logic                  frame_ready;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  // PENDING is the only state where the back bank holds an unconsumed frame,
  // so it is the only state that refuses writes.
  assign wr_ready    = (state_q != PENDING);
  assign frame_ready = (state_q != EMPTY);
  assign wr_accept   = bus.wr_en & wr_ready;
  assign rd_accept   = bus.rd_en & frame_ready;
  assign overrun_set = ~wr_ready & (bus.wr_en | bus.wr_frame_done);

  // Next-state logic: decides when the banks swap.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.wr_frame_done) begin
          swap    = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (bus.wr_frame_done && bus.rd_frame_end) begin
          swap = 1'b1;
        end else if (bus.wr_frame_done) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (bus.rd_frame_end) begin
          swap    = 1'b1;
          state_d = VALID;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Control registers: state, bank select, swap counter and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      front_sel_q  <= 1'b0;
      swap_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap) begin
        front_sel_q  <= ~front_sel_q;
        swap_count_q <= swap_count_q + 1'b1;
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Bank storage: writes always land in the current back bank (pre-swap select).
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{~front_sel_q, bus.wr_addr}] <= bus.wr_data;
    end
  end

  // Read stage p1: front bank sampled with the pre-swap select; data holds when no valid read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_accept;
      if (rd_accept) begin
        rd_data_p1 <= mem[{front_sel_q, bus.rd_addr}];
      end
    end
  end

  assign bus.rd_data     = rd_data_p1;
  assign bus.rd_valid    = vld_p1;
  assign bus.wr_ready    = wr_ready;
  assign bus.wr_bank     = ~front_sel_q;
  assign bus.frame_ready = frame_ready;
  assign bus.overrun     = overrun_q;
  assign bus.swap_count  = swap_count_q;
endmodule
